// File: rtl/dm_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer: lane select encodings
// and default parameter values.
package dm_pkg;

  localparam logic SEL_LANE0 = 1'b0;
  localparam logic SEL_LANE1 = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/dm_fifo.sv
// Small synchronous FIFO with extra-MSB pointers. When empty, head_data keeps
// showing the last popped word (0 after reset).
module dm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_data = empty ? last_q : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    mem_d  = mem_q;
    last_d = last_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + 1'b1;
    end
    // Remember the popped word so an emptied lane still presents it.
    if (do_pop) begin
      last_d = mem_q[rd_q[AW-1:0]];
      rd_d   = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      last_q <= last_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/dm1x2_stream.sv
// 1-to-2 valid/ready demultiplexer: 'selection' steers each input word into one
// of two per-lane FIFOs; per-lane counters track accepted words.
module dm1x2_stream
  import dm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             selection,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  // Handshake: a word moves on a rising edge where valid && ready. Ready never
  // depends on the same-side valid, and in_ready only looks at selection and
  // registered FIFO state, so a lane popping does not free space that cycle.

  logic             full0, full1;
  logic             empty0, empty1;
  logic             push0, push1;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  assign in_ready = (selection == SEL_LANE1) ? !full1 : !full0;
  assign push0    = in_valid && in_ready && (selection == SEL_LANE0);
  assign push1    = in_valid && in_ready && (selection == SEL_LANE1);

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (push0) cnt0_d = cnt0_q + 1'b1;
    if (push1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  dm_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (out0_ready),
    .full      (full0),
    .empty     (empty0),
    .head_data (out0_data)
  );

  dm_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (out1_ready),
    .full      (full1),
    .empty     (empty1),
    .head_data (out1_data)
  );

endmodule

// File: tb/tb_dm1x2_stream.sv
// Bench for dm1x2_stream with 4-bit counters so the wrap is reachable quickly.
module tb_dm1x2_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             selection;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid, out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  dm1x2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .selection  (selection),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid && $isunknown(selection)) begin
      errors++;
      $display("FAIL sel_x: selection=%b while in_valid=1, required 0 or 1", selection);
    end
  end

  typedef struct {
    logic             v;
    logic             sel;
    logic [WIDTH-1:0] d;
    logic             r0;
    logic             r1;
    logic             e_rdy;
    logic             e_v0;
    logic [WIDTH-1:0] e_d0;
    logic             e_v1;
    logic [WIDTH-1:0] e_d1;
    logic [CNT_W-1:0] e_c0;
    logic [CNT_W-1:0] e_c1;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    selection  = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic v0,
                           input logic [WIDTH-1:0] d0, input logic v1,
                           input logic [WIDTH-1:0] d1, input logic [CNT_W-1:0] c0,
                           input logic [CNT_W-1:0] c1);
    check({tag, ".in_ready"},   32'(in_ready),   32'(rdy));
    check({tag, ".out0_valid"}, 32'(out0_valid), 32'(v0));
    check({tag, ".out0_data"},  32'(out0_data),  32'(d0));
    check({tag, ".out1_valid"}, 32'(out1_valid), 32'(v1));
    check({tag, ".out1_data"},  32'(out1_data),  32'(d1));
    check({tag, ".cnt0"},       32'(cnt0),       32'(c0));
    check({tag, ".cnt1"},       32'(cnt1),       32'(c1));
  endtask

  initial begin
    //          v  sel d      r0 r1 rdy v0 d0     v1 d1     c0 c1
    // Steering
    vecs[0]  = '{1, 0, 8'hA5, 1, 1, 1,  0, 8'h00, 0, 8'h00, 0, 0};
    vecs[1]  = '{1, 1, 8'h3C, 1, 1, 1,  1, 8'hA5, 0, 8'h00, 1, 0};
    vecs[2]  = '{0, 0, 8'h00, 1, 1, 1,  0, 8'hA5, 1, 8'h3C, 1, 1};
    // Lane 0 stall, lane 1 keeps accepting, full lane ignores its own pop
    vecs[3]  = '{1, 0, 8'h11, 0, 1, 1,  0, 8'hA5, 0, 8'h3C, 1, 1};
    vecs[4]  = '{1, 0, 8'h22, 0, 1, 1,  1, 8'h11, 0, 8'h3C, 2, 1};
    vecs[5]  = '{1, 0, 8'h33, 0, 1, 0,  1, 8'h11, 0, 8'h3C, 3, 1};
    vecs[6]  = '{1, 1, 8'h44, 0, 0, 1,  1, 8'h11, 0, 8'h3C, 3, 1};
    vecs[7]  = '{1, 0, 8'h33, 1, 0, 0,  1, 8'h11, 1, 8'h44, 3, 2};
    vecs[8]  = '{1, 0, 8'h33, 0, 0, 1,  1, 8'h22, 1, 8'h44, 3, 2};
    // Lane 1 full with pop in the same cycle
    vecs[9]  = '{1, 1, 8'h55, 0, 0, 1,  1, 8'h22, 1, 8'h44, 4, 2};
    vecs[10] = '{1, 1, 8'h66, 0, 1, 0,  1, 8'h22, 1, 8'h44, 4, 3};
    vecs[11] = '{1, 1, 8'h66, 1, 1, 1,  1, 8'h22, 1, 8'h55, 4, 3};
    vecs[12] = '{0, 0, 8'h00, 1, 1, 1,  1, 8'h33, 1, 8'h66, 4, 4};
    vecs[13] = '{0, 0, 8'h00, 1, 1, 1,  0, 8'h33, 0, 8'h66, 4, 4};

    // Test 1: reset values
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    repeat (2) @(negedge clk);
    #1 check_all("reset", 1, 0, 8'h00, 0, 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tests 2-4: table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].r0, vecs[i].r1);
      #1 check_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_v0, vecs[i].e_d0,
                   vecs[i].e_v1, vecs[i].e_d1, vecs[i].e_c0, vecs[i].e_c1);
    end

    // Test 6: mid-operation reset discards queued words
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, (i >= 2), 8'(8'h80 + i), 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 0);
    #1 check("midrst.pre_v0", 32'(out0_valid), 32'd1);
    check("midrst.pre_v1", 32'(out1_valid), 32'd1);
    check("midrst.pre_cnt0", 32'(cnt0), 32'd6);
    #2 rst_n = 1'b0;
    #1 check_all("midrst", 1, 0, 8'h00, 0, 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_all($sformatf("postrst%0d", i), 1, 0, 8'h00, 0, 8'h00, 0, 0);
    end

    // Test 5: counter wrap with scoreboard on lane 0 data
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(1, 0, 8'($urandom_range(0, 255)), 1, 1);
      #1;
      if (out0_valid) begin
        if (exp_q.size() == 0) begin
          check("wrap.unexpected_word", 32'(out0_valid), 32'd0);
        end else begin
          check($sformatf("wrap.data%0d", i), 32'(out0_data), 32'(exp_q.pop_front()));
        end
      end
      check($sformatf("wrap.rdy%0d", i), 32'(in_ready), 32'd1);
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
    @(negedge clk);
    drive(0, 0, 8'h00, 1, 1);
    #1;
    check("wrap.last_valid", 32'(out0_valid), 32'd1);
    if (exp_q.size() != 0) check("wrap.last_data", 32'(out0_data), 32'(exp_q.pop_front()));
    check("wrap.cnt0", 32'(cnt0), 32'd1);
    check("wrap.cnt1", 32'(cnt1), 32'd0);
    check("wrap.queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #1 check("wrap.drained", 32'(out0_valid), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
